// File: rtl/compositor_pkg.sv
// Shared types, colour-key default and colour helpers for the sprite compositor.
package compositor_pkg;

  typedef logic [11:0] rgb444_t;
  typedef logic [9:0]  coord_t;

  localparam rgb444_t KEY_DEFAULT = 12'hF0F;

  // 4-bit DAC channel to 8 bits by nibble replication.
  function automatic logic [7:0] expand4to8(input logic [3:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/spr_hit_addr.sv
// Per-sprite hit test and ROM address generation (combinational).
// With COMPOSITOR_BBOX_EN defined, also flags pixels on the sprite's bounding-box edge.
module spr_hit_addr
  import compositor_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  coord_t              draw_x_i,
  input  coord_t              draw_y_i,
  input  coord_t              spr_x_i,
  input  coord_t              spr_y_i,
  input  coord_t              spr_size_i,
  input  logic                spr_en_i,
  output logic                hit_o,
`ifdef COMPOSITOR_BBOX_EN
  output logic                bbox_edge_o,
`endif
  output logic [ADDR_W-1:0]   rom_addr_o
);

  localparam int unsigned PW = ADDR_W + 20;

  coord_t dist_x_s;
  coord_t dist_y_s;

  // Modulo-1024 distances: a pixel left of / above the sprite wraps large and misses.
  always_comb begin
    dist_x_s   = draw_x_i - spr_x_i;
    dist_y_s   = draw_y_i - spr_y_i;
    hit_o      = spr_en_i & (dist_x_s < spr_size_i) & (dist_y_s < spr_size_i);
    rom_addr_o = ADDR_W'(PW'(dist_y_s) * PW'(spr_size_i) + PW'(dist_x_s));
  end

`ifdef COMPOSITOR_BBOX_EN
  // Edge test is only meaningful inside the box, so it is qualified by the hit.
  always_comb begin
    bbox_edge_o = hit_o & ((dist_x_s == 10'd0) | (dist_x_s == spr_size_i - 10'd1) |
                           (dist_y_s == 10'd0) | (dist_y_s == spr_size_i - 10'd1));
  end
`endif

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite compositor: fixed priority, colour-key transparency, 2-stage pipeline, blade collisions.
// Optional red bounding-box overlay when COMPOSITOR_BBOX_EN is defined.
module sprite_compositor
  import compositor_pkg::*;
#(
  parameter int unsigned N_SPR   = 4,
  parameter int unsigned ADDR_W  = 12,
  parameter rgb444_t     KEY_RGB = KEY_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_valid_in,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    frame_start,
  input  logic [11:0]             bkg_rgb,
  input  logic [N_SPR*10-1:0]     spr_x,
  input  logic [N_SPR*10-1:0]     spr_y,
  input  logic [N_SPR*10-1:0]     spr_size,
  input  logic [N_SPR-1:0]        spr_en,
  output logic [N_SPR*ADDR_W-1:0] rom_addr,
  input  logic [N_SPR*12-1:0]     rom_rgb,
  output logic [7:0]              Red,
  output logic [7:0]              Green,
  output logic [7:0]              Blue,
  output logic                    pix_valid_out,
  output logic [N_SPR-2:0]        collide
);

  logic [N_SPR-1:0] hit_s;
`ifdef COMPOSITOR_BBOX_EN
  logic [N_SPR-1:0] edge_s;
  logic             edge_q;
`endif

  for (genvar g = 0; g < N_SPR; g++) begin : g_spr
    spr_hit_addr #(.ADDR_W(ADDR_W)) u_hit (
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .spr_x_i    (spr_x[g*10 +: 10]),
      .spr_y_i    (spr_y[g*10 +: 10]),
      .spr_size_i (spr_size[g*10 +: 10]),
      .spr_en_i   (spr_en[g]),
      .hit_o      (hit_s[g]),
`ifdef COMPOSITOR_BBOX_EN
      .bbox_edge_o(edge_s[g]),
`endif
      .rom_addr_o (rom_addr[g*ADDR_W +: ADDR_W])
    );
  end

  logic [N_SPR-1:0] hit_q;
  rgb444_t          bkg_q;
  logic             valid_q;

  // Stage 1 register: aligns hit/background with the one-cycle ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_q   <= '0;
      bkg_q   <= '0;
      valid_q <= 1'b0;
`ifdef COMPOSITOR_BBOX_EN
      edge_q  <= 1'b0;
`endif
    end else begin
      hit_q   <= hit_s;
      bkg_q   <= bkg_rgb;
      valid_q <= pix_valid_in;
`ifdef COMPOSITOR_BBOX_EN
      edge_q  <= |edge_s;
`endif
    end
  end

  logic [N_SPR-1:0] opaque_s;
  logic             found_s;
  rgb444_t          pix_s;

  // Lowest-index opaque sprite wins; background otherwise; black outside active video.
  always_comb begin
    opaque_s = '0;
    found_s  = 1'b0;
    pix_s    = bkg_q;
    for (int i = 0; i < N_SPR; i++) begin
      opaque_s[i] = hit_q[i] & (rom_rgb[i*12 +: 12] != KEY_RGB);
      if (opaque_s[i] && !found_s) begin
        pix_s   = rom_rgb[i*12 +: 12];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
`ifdef COMPOSITOR_BBOX_EN
    if (edge_q) begin
      pix_s = 12'hF00;
    end else begin
      pix_s = pix_s;
    end
`endif
    if (!valid_q) begin
      pix_s = 12'h000;
    end else begin
      pix_s = pix_s;
    end
  end

  logic [7:0] red_q, green_q, blue_q;
  logic [7:0] red_d, green_d, blue_d;
  logic       pv_q;

  // Stage 2 next-state: channel expansion.
  always_comb begin
    red_d   = expand4to8(pix_s[11:8]);
    green_d = expand4to8(pix_s[7:4]);
    blue_d  = expand4to8(pix_s[3:0]);
  end

  // Stage 2 register: DAC-facing colour and valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
      pv_q    <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      pv_q    <= valid_q;
    end
  end

  assign Red           = red_q;
  assign Green         = green_q;
  assign Blue          = blue_q;
  assign pix_valid_out = pv_q;

  logic [N_SPR-2:0] coll_set_s;
  logic [N_SPR-2:0] sticky_q, sticky_d;
  logic [N_SPR-2:0] collide_q, collide_d;

  // Frame boundary publishes the previous frame's flags; its clear beats a same-cycle set.
  always_comb begin
    for (int k = 1; k < N_SPR; k++) begin
      coll_set_s[k-1] = valid_q & opaque_s[0] & opaque_s[k];
    end
    if (frame_start) begin
      sticky_d  = '0;
      collide_d = sticky_q;
    end else begin
      sticky_d  = sticky_q | coll_set_s;
      collide_d = collide_q;
    end
  end

  // Collision flag registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sticky_q  <= '0;
      collide_q <= '0;
    end else begin
      sticky_q  <= sticky_d;
      collide_q <= collide_d;
    end
  end

  assign collide = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with a registered sprite-ROM model.
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int AW = 12;

  logic            Clk;
  logic            Reset;
  logic            pix_valid_in;
  logic [9:0]      DrawX, DrawY;
  logic            frame_start;
  logic [11:0]     bkg_rgb;
  logic [N*10-1:0] spr_x, spr_y, spr_size;
  logic [N-1:0]    spr_en;
  logic [N*AW-1:0] rom_addr;
  logic [N*12-1:0] rom_rgb;
  logic [7:0]      Red, Green, Blue;
  logic            pix_valid_out;
  logic [N-2:0]    collide;

  logic [11:0]     rom_val [N];
  logic [N-1:0]    use_addr;

  int n_vec = 0;
  int n_err = 0;

  sprite_compositor #(.N_SPR(N), .ADDR_W(AW), .KEY_RGB(12'hF0F)) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in),
    .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start), .bkg_rgb(bkg_rgb),
    .spr_x(spr_x), .spr_y(spr_y), .spr_size(spr_size), .spr_en(spr_en),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .Red(Red), .Green(Green), .Blue(Blue),
    .pix_valid_out(pix_valid_out), .collide(collide)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sprite ROMs: data one cycle after the address; either echo the address or a fixed colour.
  always @(posedge Clk) begin
    for (int i = 0; i < N; i++) begin
      rom_rgb[i*12 +: 12] <= use_addr[i] ? rom_addr[i*AW +: 12] : rom_val[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
    spr_x[i*10 +: 10]    = x;
    spr_y[i*10 +: 10]    = y;
    spr_size[i*10 +: 10] = s;
  endtask

  // One valid pixel, then a bubble; output is sampled two cycles after it was driven.
  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic [11:0] bkg,
                       input logic [23:0] exp, input string tag);
    @(negedge Clk);
    DrawX = x; DrawY = y; bkg_rgb = bkg; pix_valid_in = 1'b1;
    @(negedge Clk);
    pix_valid_in = 1'b0;
    @(negedge Clk);
    check_eq({tag, " rgb"}, {8'h00, Red, Green, Blue}, {8'h00, exp});
    check_eq({tag, " pv"}, {31'd0, pix_valid_out}, 32'd1);
  endtask

  task automatic frame_pulse();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; pix_valid_in = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    frame_start = 1'b0; bkg_rgb = 12'h000; spr_en = '0; use_addr = '0;
    spr_x = '0; spr_y = '0; spr_size = '0;
    for (int i = 0; i < N; i++) rom_val[i] = 12'h000;

    repeat (3) @(negedge Clk);
    check_eq("reset rgb", {8'h00, Red, Green, Blue}, 32'd0);
    check_eq("reset pv", {31'd0, pix_valid_out}, 32'd0);
    check_eq("reset collide", {29'd0, collide}, 32'd0);
    Reset = 1'b0;

    // Single sprite, ROM echoes its address.
    set_spr(1, 10'd100, 10'd50, 10'd32);
    spr_en = 4'b0010; use_addr = 4'b0010;
    @(negedge Clk);
    DrawX = 10'd110; DrawY = 10'd60;
    #1 check_eq("addr1", {20'd0, rom_addr[23:12]}, 32'd330);
    pixel(10'd110, 10'd60, 12'h000, 24'h1144AA, "spr1_a");
    pixel(10'd103, 10'd59, 12'h000, 24'h112233, "spr1_b");

    // Invalid pixel is blanked even with a non-black background.
    @(negedge Clk);
    DrawX = 10'd110; DrawY = 10'd60; bkg_rgb = 12'hFFF; pix_valid_in = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check_eq("blank rgb", {8'h00, Red, Green, Blue}, 32'd0);
    check_eq("blank pv", {31'd0, pix_valid_out}, 32'd0);

    // Priority and transparency.
    use_addr = 4'b0000;
    set_spr(2, 10'd120, 10'd70, 10'd16);
    spr_en = 4'b0110;
    rom_val[1] = 12'hF0F; rom_val[2] = 12'h0A0;
    pixel(10'd125, 10'd75, 12'h456, 24'h00AA00, "key_pass");
    rom_val[1] = 12'hF00;
    pixel(10'd125, 10'd75, 12'h456, 24'hFF0000, "prio");
    pixel(10'd300, 10'd300, 12'h456, 24'h445566, "bkg");

    // Left wrap and zero size.
    set_spr(1, 10'd5, 10'd0, 10'd32);
    spr_en = 4'b0010; rom_val[1] = 12'h0F0;
    pixel(10'd2, 10'd10, 12'h789, 24'h778899, "wrap_miss");
    pixel(10'd6, 10'd10, 12'h789, 24'h00FF00, "wrap_hit");
    set_spr(1, 10'd100, 10'd50, 10'd0);
    pixel(10'd100, 10'd50, 12'h789, 24'h778899, "size0");

    // Collisions with the blade.
    set_spr(0, 10'd200, 10'd200, 10'd8);
    set_spr(3, 10'd204, 10'd204, 10'd8);
    rom_val[0] = 12'h111; rom_val[3] = 12'h333;
    spr_en = 4'b1001;
    frame_pulse();
    check_eq("coll_init", {29'd0, collide}, 32'd0);
    pixel(10'd205, 10'd205, 12'h000, 24'h111111, "blade_prio");
    frame_pulse();
    check_eq("coll_03", {29'd0, collide}, 32'b100);
    pixel(10'd300, 10'd300, 12'h000, 24'h000000, "no_overlap");
    frame_pulse();
    check_eq("coll_none", {29'd0, collide}, 32'd0);

    // Set in the same cycle as frame_start is dropped.
    @(negedge Clk);
    DrawX = 10'd205; DrawY = 10'd205; pix_valid_in = 1'b1;
    @(negedge Clk);
    pix_valid_in = 1'b0; frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    check_eq("coin_report", {29'd0, collide}, 32'd0);
    frame_pulse();
    check_eq("coin_clear", {29'd0, collide}, 32'd0);

    // Keyed sprite 3 does not collide.
    rom_val[3] = 12'hF0F;
    pixel(10'd205, 10'd205, 12'h000, 24'h111111, "keyed_px");
    frame_pulse();
    check_eq("coll_keyed", {29'd0, collide}, 32'd0);

    // Two sprites against the blade in one frame.
    rom_val[3] = 12'h333; rom_val[1] = 12'h0F0;
    set_spr(1, 10'd203, 10'd203, 10'd4);
    spr_en = 4'b1011;
    pixel(10'd205, 10'd205, 12'h000, 24'h111111, "two_px");
    frame_pulse();
    check_eq("coll_013", {29'd0, collide}, 32'b101);

    // Reset with a full pipeline, then restart.
    spr_en = 4'b0000;
    @(negedge Clk);
    DrawX = 10'd300; DrawY = 10'd300; bkg_rgb = 12'hABC; pix_valid_in = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check_eq("stream rgb", {8'h00, Red, Green, Blue}, 32'h00AABBCC);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("rst_mid rgb", {8'h00, Red, Green, Blue}, 32'd0);
    check_eq("rst_mid pv", {31'd0, pix_valid_out}, 32'd0);
    check_eq("rst_mid collide", {29'd0, collide}, 32'd0);
    Reset = 1'b0; pix_valid_in = 1'b0;
    @(negedge Clk);
    check_eq("post_rst pv0", {31'd0, pix_valid_out}, 32'd0);
    pix_valid_in = 1'b1;
    @(negedge Clk);
    check_eq("post_rst pv1", {31'd0, pix_valid_out}, 32'd0);
    @(negedge Clk);
    check_eq("post_rst pv2", {31'd0, pix_valid_out}, 32'd1);
    check_eq("post_rst rgb", {8'h00, Red, Green, Blue}, 32'h00AABBCC);
    pix_valid_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
